lifo_reverse_ctrl: RTL and testbench

- Controller that sits directly upstream of, and drives, the 5-bit up/down counter: generates cnt_up / cnt_down / cnt_clr and consumes its count and zero flag.
- Accepts a burst of up to 31 words on a valid/ready input, stores each at the current count, then drains them in reverse (LIFO) order on a valid/ready output.
- Used as the stack/reversal stage feeding the downstream datapath.

---
 rtl/lifo_reverse_ctrl.sv | 106 ++++++++++
 tb/tb_lifo_reverse_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_reverse_ctrl.sv
// LIFO reversal stage: stacks a burst of up to 31 words at the external counter's value, then drains them newest-first.
// Latency: first out_valid the cycle after the last input handshake; one word/cycle in and out.
// Backpressure: in_ready drops once 31 words are held; out_data/out_valid hold steady while out_ready is low.
module lifo_reverse_ctrl #(
    parameter int W   = 8,
    parameter int CAP = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         done,
    output logic         busy,
    output logic         cnt_up,
    output logic         cnt_down,
    output logic         cnt_clr,
    input  logic [4:0]   cnt_val,
    input  logic         cnt_zero
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [4:0] CAP5 = 5'(CAP);
    localparam logic [4:0] TOP5 = 5'(CAP - 1);

    state_t       state, state_nxt;
    logic         done_nxt;
    logic [W-1:0] mem [0:CAP-1];
    logic [4:0]   rd_idx;
    logic         in_hs, out_hs;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // Top of stack sits one below the count; guard the empty case so the read never leaves the array.
    assign rd_idx   = cnt_val - 5'd1;
    assign out_data = (rd_idx < CAP5) ? mem[rd_idx] : '0;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        cnt_up    = 1'b0;
        cnt_down  = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start) state_nxt = FILL;
            end
            FILL: begin
                busy     = 1'b1;
                in_ready = (cnt_val < CAP5);
                if (in_hs) begin
                    cnt_up = 1'b1;
                    if (in_last || cnt_val == TOP5) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = ~cnt_zero;
                out_last  = ~cnt_zero && (cnt_val == 5'd1);
                if (out_hs) begin
                    cnt_down = 1'b1;
                    if (cnt_val == 5'd1) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over everything in flight: no counter motion, no completion pulse.
        if (flush) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
            cnt_up    = 1'b0;
            cnt_down  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && in_hs && !flush) mem[cnt_val] <= in_data;
    end
endmodule

// File: tb/tb_lifo_reverse_ctrl.sv
// Bench for lifo_reverse_ctrl: models the 5-bit up/down counter and scoreboards the reversed output stream.
module tb_lifo_reverse_ctrl;
    localparam int W = 8;

    logic         clk, rst, start, flush;
    logic         in_valid, in_ready, in_last;
    logic [W-1:0] in_data, out_data;
    logic         out_valid, out_ready, out_last;
    logic         done, busy, cnt_up, cnt_down, cnt_clr, cnt_zero;
    logic [4:0]   cnt_val = 5'd0;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic       prev_final = 1'b0;
    int         n_up = 0, n_down = 0, n_acc = 0;
    int         up0, dn0, acc0;

    lifo_reverse_ctrl #(.W(W), .CAP(31)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .busy(busy), .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_clr(cnt_clr),
        .cnt_val(cnt_val), .cnt_zero(cnt_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The counter this controller drives.
    assign cnt_zero = (cnt_val == 5'd0);
    always @(posedge clk) begin
        if (cnt_clr)       cnt_val <= 5'd0;
        else if (cnt_up)   cnt_val <= cnt_val + 5'd1;
        else if (cnt_down) cnt_val <= cnt_val - 5'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, done timing and counter-contract invariants.
    always @(negedge clk) begin
        if (!rst) begin
            chk("down_at_zero", 32'(cnt_down & cnt_zero), 32'd0);
            chk("up_with_down", 32'(cnt_up & cnt_down), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[7:0]));
                    chk("out_last", 32'(out_last), 32'(e[8]));
                end
            end
            if (done || prev_final) chk("done_pulse", 32'(done), 32'(prev_final));
            n_up   = n_up + (cnt_up ? 1 : 0);
            n_down = n_down + (cnt_down ? 1 : 0);
            n_acc  = n_acc + ((in_valid && in_ready) ? 1 : 0);
        end
        prev_final = out_valid & out_ready & out_last & ~flush & ~rst;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic begin_burst;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 200) begin
            step;
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy, exp_q.size());
        end
        step;
        chk({name, "_cnt_zero"}, 32'(cnt_val), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cnt_clr", 32'(cnt_clr), 32'd1);
        chk("rst_outputs", 32'({in_ready, out_valid, out_last, busy, cnt_up, cnt_down, done}), 32'd0);
        step;
        rst = 1'b0;
        step;

        // 1: burst of three, full-rate drain
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h33});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h11});
        begin_burst;
        offer(8'h11, 1'b0);
        offer(8'h22, 1'b0);
        offer(8'h33, 1'b1);
        @(negedge clk);
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        wait_idle("t1");

        // 2: 40 offered, 31 accepted
        up0 = n_up; dn0 = n_down; acc0 = n_acc;
        for (int v = 31; v >= 1; v--) exp_q.push_back({(v == 1), 8'(v)});
        begin_burst;
        for (int i = 1; i <= 40; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = 1'b0;
            if (i == 31) begin
                @(negedge clk);
                chk("t2_ready_word31", 32'(in_ready), 32'd1);
            end
            if (i == 32) begin
                @(negedge clk);
                chk("t2_ready_word32", 32'(in_ready), 32'd0);
            end
            step;
        end
        in_valid = 1'b0;
        wait_idle("t2");
        chk("t2_accepted", 32'(n_acc - acc0), 32'd31);
        chk("t2_up_pulses", 32'(n_up - up0), 32'd31);
        chk("t2_down_pulses", 32'(n_down - dn0), 32'd31);

        // 3: output backpressure
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b1, 8'hA0});
        begin_burst;
        offer(8'hA0, 1'b0);
        offer(8'hA1, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_valid", 32'(out_valid), 32'd1);
            chk("t3_stall_data", 32'(out_data), 32'hA1);
            chk("t3_stall_down", 32'(cnt_down), 32'd0);
        end
        step;
        out_ready = 1'b1;
        wait_idle("t3");

        // 4: flush in DRAIN at count 4, then a one-word burst
        out_ready = 1'b0;
        begin_burst;
        offer(8'h01, 1'b0);
        offer(8'h02, 1'b0);
        offer(8'h03, 1'b0);
        offer(8'h04, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("t4_cnt_before", 32'(cnt_val), 32'd4);
        chk("t4_flush_clr", 32'(cnt_clr), 32'd1);
        chk("t4_flush_no_down", 32'(cnt_down), 32'd0);
        step;
        flush = 1'b0;
        @(negedge clk);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_clr", 32'(cnt_clr), 32'd1);
        chk("t4_idle_cnt", 32'(cnt_val), 32'd0);
        chk("t4_no_done", 32'(done), 32'd0);
        step;
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 8'h5A});
        begin_burst;
        offer(8'h5A, 1'b1);
        wait_idle("t4");

        // 5: asynchronous reset mid-FILL at count 7
        begin_burst;
        for (int i = 1; i <= 7; i++) offer(8'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h08;
        #2;
        chk("t5_pre_cnt", 32'(cnt_val), 32'd7);
        chk("t5_pre_up", 32'(cnt_up), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_ready", 32'(in_ready), 32'd0);
        chk("t5_async_up", 32'(cnt_up), 32'd0);
        chk("t5_async_clr", 32'(cnt_clr), 32'd1);
        in_valid = 1'b0;
        step;
        step;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_after_busy", 32'(busy), 32'd0);
        chk("t5_after_clr", 32'(cnt_clr), 32'd1);
        chk("t5_after_cnt", 32'(cnt_val), 32'd0);
        step;

        // 6: single-word burst
        exp_q.push_back({1'b1, 8'hFF});
        begin_burst;
        offer(8'hFF, 1'b1);
        @(negedge clk);
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_data", 32'(out_data), 32'hFF);
        chk("t6_last", 32'(out_last), 32'd1);
        wait_idle("t6");

        repeat (3) step;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
